// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI lane scheduler: FSM states, owner encoding
// and the physical lane ceiling.
package dsi_pkg;

  localparam int unsigned c_max_lanes = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LP_XFER,
    ST_HS_START,
    ST_HS_XFER,
    ST_HS_DRAIN,
    ST_GUARD,
    ST_WAIT_IDLE
  } state_t;

  typedef enum logic {
    GNT_HS,
    GNT_LP
  } grant_t;

  // Lanes 0..n_m1 set, higher lanes clear.
  function automatic logic [c_max_lanes-1:0] lane_mask(input logic [1:0] n_m1);
    lane_mask = 4'hF >> (2'd3 - n_m1);
  endfunction

endpackage

// File: rtl/dsi_lane_stripe.sv
// Registered beat-to-lane mapper: captures an accepted HS beat and produces
// the per-lane valid mask for the following cycle.
module dsi_lane_stripe
  import dsi_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     accept_i,
  input  logic [8*c_max_lanes-1:0] data_i,
  input  logic [2:0]               bytes_i,
  input  logic [1:0]               n_m1_i,
  output logic [c_max_lanes-1:0]   valid_o,
  output logic [8*c_max_lanes-1:0] data_o
);

  logic [2:0]             n_lanes;
  logic [2:0]             eff_bytes;
  logic [c_max_lanes-1:0] mask_d;

  assign n_lanes = {1'b0, n_m1_i} + 3'd1;

  // Effective byte count: 0 or more than N means a full beat of N bytes.
  always_comb begin
    eff_bytes = bytes_i;
    if (bytes_i == 3'd0 || bytes_i > n_lanes) begin
      eff_bytes = n_lanes;
    end
    mask_d = 4'hF >> (3'd4 - eff_bytes);
  end

  // Valid pulses only for one cycle per accepted beat; data holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= '0;
      data_o  <= '0;
    end else begin
      valid_o <= accept_i ? mask_d : '0;
      if (accept_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/dsi_lane_scheduler.sv
// Shares the D-PHY lanes between the HS packet stream and the LP escape
// command stream: arbitration, HS striping, drain, guard and idle check.
module dsi_lane_scheduler
  import dsi_pkg::*;
#(
  parameter int unsigned g_num_lanes   = 4,
  parameter int unsigned g_guard_ticks = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tick_i,
  input  logic [1:0]               num_lanes_i,
  input  logic                     hs_req_i,
  input  logic [8*c_max_lanes-1:0] hs_data_i,
  input  logic [2:0]               hs_bytes_i,
  input  logic                     hs_last_i,
  input  logic                     hs_valid_i,
  output logic                     hs_ready_o,
  input  logic                     lp_req_i,
  input  logic [7:0]               lp_data_i,
  input  logic                     lp_valid_i,
  input  logic                     lp_last_i,
  output logic                     lp_ready_o,
  output logic                     phy_hs_request_o,
  output logic [c_max_lanes-1:0]   phy_hs_valid_o,
  output logic [8*c_max_lanes-1:0] phy_hs_data_o,
  input  logic [c_max_lanes-1:0]   phy_hs_ready_i,
  output logic                     phy_lp_request_o,
  output logic [7:0]               phy_lp_data_o,
  output logic                     phy_lp_valid_o,
  input  logic                     phy_lp_ready_i,
  input  logic [c_max_lanes-1:0]   phy_idle_i,
  output logic                     busy_o,
  output logic                     grant_hs_o,
  output logic                     grant_lp_o
);

  localparam logic [1:0] c_max_n_m1   = 2'(g_num_lanes - 1);
  localparam logic [3:0] c_guard_last = 4'(g_guard_ticks - 1);

  state_t                 state_q, state_d;
  grant_t                 owner_q, last_grant_q;
  logic [1:0]             n_m1_q, n_m1_grant;
  logic [3:0]             guard_cnt_q;
  logic                   guard_first_q;
  logic                   drain_cnt_q;
  logic [c_max_lanes-1:0] act_mask;
  logic                   all_rdy, all_idle, hs_accept;

  // A lane count above the instantiated lanes is clamped at grant time.
  assign n_m1_grant = (num_lanes_i > c_max_n_m1) ? c_max_n_m1 : num_lanes_i;
  assign act_mask   = lane_mask(n_m1_q);
  assign all_rdy    = &(phy_hs_ready_i | ~act_mask);
  assign all_idle   = &(phy_idle_i | ~act_mask);

  assign busy_o     = (state_q != ST_IDLE);
  assign grant_hs_o = busy_o && (owner_q == GNT_HS);
  assign grant_lp_o = busy_o && (owner_q == GNT_LP);

  // Next-state decode and per-state lane request / handshake outputs.
  always_comb begin
    state_d          = state_q;
    hs_ready_o       = 1'b0;
    hs_accept        = 1'b0;
    lp_ready_o       = 1'b0;
    phy_hs_request_o = 1'b0;
    phy_lp_request_o = 1'b0;
    phy_lp_data_o    = '0;
    phy_lp_valid_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // LP wins a tie when HS had the previous grant.
        if (lp_req_i && (!hs_req_i || last_grant_q == GNT_HS)) begin
          state_d = ST_LP_XFER;
        end else if (hs_req_i) begin
          state_d = ST_HS_START;
        end
      end
      ST_LP_XFER: begin
        phy_lp_request_o = 1'b1;
        phy_lp_data_o    = lp_data_i;
        phy_lp_valid_o   = lp_valid_i;
        lp_ready_o       = phy_lp_ready_i;
        if (lp_valid_i && phy_lp_ready_i && lp_last_i) begin
          state_d = ST_GUARD;
        end
      end
      ST_HS_START: begin
        phy_hs_request_o = 1'b1;
        if (all_rdy) begin
          state_d = ST_HS_XFER;
        end
      end
      ST_HS_XFER: begin
        phy_hs_request_o = 1'b1;
        hs_ready_o       = all_rdy;
        hs_accept        = all_rdy && hs_valid_i;
        if (hs_accept && hs_last_i) begin
          state_d = ST_HS_DRAIN;
        end
      end
      ST_HS_DRAIN: begin
        phy_hs_request_o = 1'b1;
        if (drain_cnt_q) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (tick_i && !guard_first_q && guard_cnt_q == c_guard_last) begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (all_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer context: owner, lane count, round-robin history, drain/guard counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q       <= GNT_HS;
      last_grant_q  <= GNT_HS;
      n_m1_q        <= '0;
      guard_cnt_q   <= '0;
      guard_first_q <= 1'b0;
      drain_cnt_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        n_m1_q  <= n_m1_grant;
        owner_q <= (state_d == ST_LP_XFER) ? GNT_LP : GNT_HS;
      end
      if (state_q == ST_WAIT_IDLE && state_d == ST_IDLE) begin
        last_grant_q <= owner_q;
      end
      drain_cnt_q   <= (state_q == ST_HS_DRAIN) && !drain_cnt_q;
      // The first GUARD cycle ignores tick_i so a tick on entry is not counted.
      guard_first_q <= (state_d == ST_GUARD) && (state_q != ST_GUARD);
      if (state_q != ST_GUARD) begin
        guard_cnt_q <= '0;
      end else if (tick_i && !guard_first_q) begin
        guard_cnt_q <= guard_cnt_q + 4'd1;
      end
    end
  end

  dsi_lane_stripe u_stripe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .accept_i (hs_accept),
    .data_i   (hs_data_i),
    .bytes_i  (hs_bytes_i),
    .n_m1_i   (n_m1_q),
    .valid_o  (phy_hs_valid_o),
    .data_o   (phy_hs_data_o)
  );

endmodule

// File: tb/tb_dsi_lane_scheduler.sv
// Directed bench for dsi_lane_scheduler with hand-computed expectations.
module tb_dsi_lane_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic [1:0]  num_lanes_i;
  logic        hs_req_i;
  logic [31:0] hs_data_i;
  logic [2:0]  hs_bytes_i;
  logic        hs_last_i;
  logic        hs_valid_i;
  logic        hs_ready_o;
  logic        lp_req_i;
  logic [7:0]  lp_data_i;
  logic        lp_valid_i;
  logic        lp_last_i;
  logic        lp_ready_o;
  logic        phy_hs_request_o;
  logic [3:0]  phy_hs_valid_o;
  logic [31:0] phy_hs_data_o;
  logic [3:0]  phy_hs_ready_i;
  logic        phy_lp_request_o;
  logic [7:0]  phy_lp_data_o;
  logic        phy_lp_valid_o;
  logic        phy_lp_ready_i;
  logic [3:0]  phy_idle_i;
  logic        busy_o;
  logic        grant_hs_o;
  logic        grant_lp_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  dsi_lane_scheduler #(
    .g_num_lanes   (4),
    .g_guard_ticks (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .tick_i           (tick_i),
    .num_lanes_i      (num_lanes_i),
    .hs_req_i         (hs_req_i),
    .hs_data_i        (hs_data_i),
    .hs_bytes_i       (hs_bytes_i),
    .hs_last_i        (hs_last_i),
    .hs_valid_i       (hs_valid_i),
    .hs_ready_o       (hs_ready_o),
    .lp_req_i         (lp_req_i),
    .lp_data_i        (lp_data_i),
    .lp_valid_i       (lp_valid_i),
    .lp_last_i        (lp_last_i),
    .lp_ready_o       (lp_ready_o),
    .phy_hs_request_o (phy_hs_request_o),
    .phy_hs_valid_o   (phy_hs_valid_o),
    .phy_hs_data_o    (phy_hs_data_o),
    .phy_hs_ready_i   (phy_hs_ready_i),
    .phy_lp_request_o (phy_lp_request_o),
    .phy_lp_data_o    (phy_lp_data_o),
    .phy_lp_valid_o   (phy_lp_valid_o),
    .phy_lp_ready_i   (phy_lp_ready_i),
    .phy_idle_i       (phy_idle_i),
    .busy_o           (busy_o),
    .grant_hs_o       (grant_hs_o),
    .grant_lp_o       (grant_lp_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Toggle tick until the scheduler returns to IDLE, bounded.
  task automatic finish_xfer(input string tag);
    int unsigned n;
    n = 0;
    while (busy_o && n < 60) begin
      tick_i = n[0];
      step();
      n++;
    end
    tick_i = 1'b0;
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; num_lanes_i = 2'd3;
    hs_req_i = 1'b1; hs_data_i = 32'hFFFF_FFFF; hs_bytes_i = 3'd4;
    hs_last_i = 1'b0; hs_valid_i = 1'b1;
    lp_req_i = 1'b1; lp_data_i = 8'hFF; lp_valid_i = 1'b1; lp_last_i = 1'b0;
    phy_hs_ready_i = 4'hF; phy_lp_ready_i = 1'b1; phy_idle_i = 4'hF;
    repeat (2) step();

    // Reset values
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst hs_ready", {31'd0, hs_ready_o}, 32'd0);
    chk("rst lp_ready", {31'd0, lp_ready_o}, 32'd0);
    chk("rst hs_req", {31'd0, phy_hs_request_o}, 32'd0);
    chk("rst lp_req", {31'd0, phy_lp_request_o}, 32'd0);
    chk("rst lp_valid", {31'd0, phy_lp_valid_o}, 32'd0);
    chk("rst lp_data", {24'd0, phy_lp_data_o}, 32'd0);
    chk("rst hs_valid", {28'd0, phy_hs_valid_o}, 32'd0);
    chk("rst hs_data", phy_hs_data_o, 32'd0);
    chk("rst grants", {30'd0, grant_hs_o, grant_lp_o}, 32'd0);

    // Simultaneous requests from reset: LP first
    hs_valid_i = 1'b0; lp_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
    chk("rr1 grant_lp", {31'd0, grant_lp_o}, 32'd1);
    chk("rr1 grant_hs", {31'd0, grant_hs_o}, 32'd0);
    chk("rr1 lp_req", {31'd0, phy_lp_request_o}, 32'd1);
    chk("rr1 hs_req", {31'd0, phy_hs_request_o}, 32'd0);

    // LP pass-through of A5, 3C
    lp_data_i = 8'hA5; lp_valid_i = 1'b1; lp_last_i = 1'b0; #1;
    chk("lp0 data", {24'd0, phy_lp_data_o}, 32'hA5);
    chk("lp0 valid", {31'd0, phy_lp_valid_o}, 32'd1);
    chk("lp0 ready", {31'd0, lp_ready_o}, 32'd1);
    step();
    lp_data_i = 8'h3C; lp_last_i = 1'b1; #1;
    chk("lp1 data", {24'd0, phy_lp_data_o}, 32'h3C);
    chk("lp1 ready", {31'd0, lp_ready_o}, 32'd1);
    step();
    lp_valid_i = 1'b0; lp_last_i = 1'b0; lp_req_i = 1'b0;
    chk("lp guard lp_req", {31'd0, phy_lp_request_o}, 32'd0);
    chk("lp guard busy", {31'd0, busy_o}, 32'd1);
    chk("lp guard owner", {31'd0, grant_lp_o}, 32'd1);

    // Guard: entry tick ignored, then exactly 4 ticks
    tick_i = 1'b1; step(); tick_i = 1'b0; step();
    repeat (3) begin
      tick_i = 1'b1; step(); tick_i = 1'b0; step();
    end
    chk("guard 3 ticks", {31'd0, busy_o}, 32'd1);
    repeat (2) step();
    chk("guard 3 ticks hold", {31'd0, busy_o}, 32'd1);
    tick_i = 1'b1; step(); tick_i = 1'b0;
    phy_idle_i = 4'h7;
    chk("wait idle 0", {31'd0, busy_o}, 32'd1);
    step();
    chk("wait idle 1", {31'd0, busy_o}, 32'd1);
    phy_idle_i = 4'hF;
    step();
    chk("idle reached", {31'd0, busy_o}, 32'd0);
    chk("idle no grant", {30'd0, grant_hs_o, grant_lp_o}, 32'd0);

    // 4-lane HS burst; lane 1 not ready at first
    phy_hs_ready_i = 4'hD; hs_valid_i = 1'b1; hs_data_i = 32'h1122_3344;
    hs_bytes_i = 3'd4; hs_last_i = 1'b0;
    step();
    chk("hs grant req", {31'd0, phy_hs_request_o}, 32'd1);
    chk("hs grant owner", {31'd0, grant_hs_o}, 32'd1);
    repeat (3) begin
      chk("hs stall ready", {31'd0, hs_ready_o}, 32'd0);
      step();
      chk("hs stall valid", {28'd0, phy_hs_valid_o}, 32'd0);
    end
    phy_hs_ready_i = 4'hF;
    step();
    chk("hs xfer ready", {31'd0, hs_ready_o}, 32'd1);
    chk("hs xfer no valid", {28'd0, phy_hs_valid_o}, 32'd0);
    step();
    chk("beat1 valid", {28'd0, phy_hs_valid_o}, 32'hF);
    chk("beat1 data", phy_hs_data_o, 32'h1122_3344);
    phy_hs_ready_i = 4'hD; hs_data_i = 32'h5566_7788; hs_bytes_i = 3'd0; #1;
    chk("mid stall ready", {31'd0, hs_ready_o}, 32'd0);
    step();
    chk("mid stall valid", {28'd0, phy_hs_valid_o}, 32'd0);
    phy_hs_ready_i = 4'hF; #1;
    chk("resume ready", {31'd0, hs_ready_o}, 32'd1);
    step();
    chk("beat2 valid", {28'd0, phy_hs_valid_o}, 32'hF);
    chk("beat2 data", phy_hs_data_o, 32'h5566_7788);
    hs_data_i = 32'hAABB_CCDD; hs_bytes_i = 3'd2; hs_last_i = 1'b1;
    step();
    chk("beat3 valid", {28'd0, phy_hs_valid_o}, 32'h3);
    chk("beat3 data", phy_hs_data_o, 32'hAABB_CCDD);
    chk("drain1 req", {31'd0, phy_hs_request_o}, 32'd1);
    hs_valid_i = 1'b0; hs_last_i = 1'b0; hs_req_i = 1'b0; #1;
    chk("drain ready", {31'd0, hs_ready_o}, 32'd0);
    step();
    chk("drain2 valid", {28'd0, phy_hs_valid_o}, 32'd0);
    chk("drain2 req", {31'd0, phy_hs_request_o}, 32'd1);
    step();
    chk("post drain req", {31'd0, phy_hs_request_o}, 32'd0);
    chk("post drain busy", {31'd0, busy_o}, 32'd1);

    // Second simultaneous pair after HS: LP again
    lp_req_i = 1'b1; hs_req_i = 1'b1;
    finish_xfer("hs1 done");
    step();
    chk("rr2 grant_lp", {31'd0, grant_lp_o}, 32'd1);
    chk("rr2 hs_req", {31'd0, phy_hs_request_o}, 32'd0);

    // Single LP byte, then 2-lane HS
    lp_data_i = 8'h5A; lp_valid_i = 1'b1; lp_last_i = 1'b1; num_lanes_i = 2'd1;
    step();
    lp_valid_i = 1'b0; lp_last_i = 1'b0; lp_req_i = 1'b0;
    finish_xfer("lp2 done");
    step();
    chk("hs2 req", {31'd0, phy_hs_request_o}, 32'd1);
    num_lanes_i = 2'd3; phy_hs_ready_i = 4'h3;
    hs_valid_i = 1'b1; hs_data_i = 32'hDEAD_BEEF; hs_bytes_i = 3'd4; hs_last_i = 1'b0;
    step();
    chk("hs2 ready", {31'd0, hs_ready_o}, 32'd1);
    step();
    chk("hs2 b1 valid", {28'd0, phy_hs_valid_o}, 32'h3);
    chk("hs2 b1 data", phy_hs_data_o, 32'hDEAD_BEEF);
    hs_data_i = 32'hCAFE_F00D; hs_bytes_i = 3'd0; hs_last_i = 1'b1;
    step();
    chk("hs2 b2 valid", {28'd0, phy_hs_valid_o}, 32'h3);
    hs_valid_i = 1'b0; hs_last_i = 1'b0; hs_req_i = 1'b0;
    step();
    chk("hs2 drain valid", {28'd0, phy_hs_valid_o}, 32'd0);
    phy_hs_ready_i = 4'hF;

    // LP-only transfer so last_grant is LP before the reset test
    lp_req_i = 1'b1;
    finish_xfer("hs2 done");
    lp_valid_i = 1'b1; lp_last_i = 1'b1; lp_data_i = 8'h11;
    step();
    chk("lp3 grant", {31'd0, grant_lp_o}, 32'd1);
    step();
    lp_req_i = 1'b0; lp_valid_i = 1'b0; lp_last_i = 1'b0; hs_req_i = 1'b1;
    finish_xfer("lp3 done");

    // HS burst interrupted by reset
    step();
    hs_valid_i = 1'b1; hs_data_i = 32'h1234_5678; hs_bytes_i = 3'd4;
    step();
    step();
    chk("hs3 valid", {28'd0, phy_hs_valid_o}, 32'hF);
    rst_i = 1'b1; lp_req_i = 1'b1;
    step();
    chk("mid rst valid", {28'd0, phy_hs_valid_o}, 32'd0);
    chk("mid rst data", phy_hs_data_o, 32'd0);
    chk("mid rst hs_req", {31'd0, phy_hs_request_o}, 32'd0);
    chk("mid rst hs_ready", {31'd0, hs_ready_o}, 32'd0);
    chk("mid rst busy", {31'd0, busy_o}, 32'd0);
    chk("mid rst grants", {30'd0, grant_hs_o, grant_lp_o}, 32'd0);
    rst_i = 1'b0; hs_valid_i = 1'b0;
    step();
    chk("post rst grant_lp", {31'd0, grant_lp_o}, 32'd1);
    chk("post rst grant_hs", {31'd0, grant_hs_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_lane_scheduler.md
# dsi_lane_scheduler

Sequences the per-lane D-PHY lane state machines of the DSI link and shares them between two requesters: the HS packet stream (video and long packets) and the LP escape-mode command stream. It sits between the packet assembler and the `dphy_lane` instances. It arbitrates between the two requesters and raises and holds the lane HS/LP requests. It stripes HS bytes across the active lanes, flushes the lane pipeline on HS exit, and enforces a guard interval plus an all-lanes-idle check before granting the next transfer.

## Interface
- `g_num_lanes`, 4 — physical lanes instantiated (1..4).
- `g_guard_ticks`, 4 — `tick_i` pulses to wait after any request drops before the next grant (1..15).

- `clk_i` in 1 — system clock.
- `rst_i` in 1 — synchronous, active-high reset.
- `tick_i` in 1 — slow LP timing tick, same one fed to the lanes.
- `num_lanes_i` in 2 — active lanes minus one; sampled at grant.
- `hs_req_i` in 1 — HS requester has a packet pending.
- `hs_data_i` in 32 — beat bytes; byte k goes to lane k.
- `hs_bytes_i` in 3 — valid bytes in the beat, counted from byte 0. A value of 0 or greater than N is treated as N.
- `hs_last_i` in 1 — final beat of the burst.
- `hs_valid_i` in 1 — beat strobe.
- `hs_ready_o` out 1 — beat accepted when high together with `hs_valid_i`.
- `lp_req_i` in 1 — LP requester pending.
- `lp_data_i` in 8, `lp_valid_i` in 1, `lp_last_i` in 1 — LP byte stream.
- `lp_ready_o` out 1 — LP byte accepted when high with `lp_valid_i`.
- `phy_hs_request_o` out 1 — to every lane's `hs_request_i`.
- `phy_hs_valid_o` out 4 — to every lane's `hs_valid_i`.
- `phy_hs_data_o` out 32 — to every lane's `hs_data_i`.
- `phy_hs_ready_i` in 4 — lane `hs_ready_o` bits.
- `phy_lp_request_o` out 1 — lane 0 `lp_request_i` only.
- `phy_lp_data_o` out 8 — to lane 0.
- `phy_lp_valid_o` out 1 — to lane 0.
- `phy_lp_ready_i` in 1 — from lane 0.
- `phy_idle_i` in 4 — lane `idle_o` bits.
- `busy_o` out 1 — high in any state other than IDLE.
- `grant_hs_o` out 1, `grant_lp_o` out 1 — current owner.

## Operation
- Let N = latched `num_lanes_i`+1. Define the active mask as lanes 0..N-1, and `all_rdy` / `all_idle` as the AND of the corresponding inputs over that mask.

**IDLE**
- If `lp_req_i` or `hs_req_i` is high, grant and latch N.
- If both are high, round-robin on `last_grant`, which resets to HS, so LP wins first.
- LP grant → LP_XFER. HS grant → HS_START.

**LP_XFER**
- `phy_lp_request_o`=1.
- `phy_lp_data_o`=`lp_data_i` and `phy_lp_valid_o`=`lp_valid_i`, combinational pass-through.
- `lp_ready_o`=`phy_lp_ready_i`.
- When a byte with `lp_last_i` is accepted → GUARD; `phy_lp_request_o` is 0 from the next cycle.

**HS_START**
- `phy_hs_request_o`=1. Wait for `all_rdy` → HS_XFER.

**HS_XFER**
- `hs_ready_o`=`all_rdy`.
- On an accepted beat, the next cycle has `phy_hs_data_o`=`hs_data_i` registered, and `phy_hs_valid_o[k]`=1 for k < min(effective bytes, N).
- Without an accepted beat, `phy_hs_valid_o`=0.
- An accepted beat with `hs_last_i` → HS_DRAIN.

**HS_DRAIN**
- Hold `phy_hs_request_o`=1 for 2 more cycles so the last beat passes the lane input registers, then drop it → GUARD.

**GUARD**
- Count `g_guard_ticks` `tick_i` pulses, then → WAIT_IDLE.

**WAIT_IDLE**
- Wait for `all_idle` → IDLE. Update `last_grant`.

**General rules**
- Bits of `phy_hs_valid_o` for inactive lanes are always 0.
- `num_lanes_i` changes during a transfer are ignored until the next grant.
- Requesters dropping `*_req_i` mid-transfer are ignored; only `*_last_i` ends a transfer.

## Timing
- Reset values:
  - state IDLE, `last_grant`=HS.
  - `hs_ready_o`, `lp_ready_o`, `phy_hs_request_o`, `phy_lp_request_o`, `phy_lp_valid_o` = 0.
  - `phy_hs_valid_o`=0, `phy_hs_data_o`=0, `phy_lp_data_o`=0.
  - `busy_o`, `grant_hs_o`, `grant_lp_o` = 0.
- Reset mid-transfer: all outputs return to reset values at the next edge, and no drain is performed.
- Grant latency: request seen in IDLE → `phy_*_request_o` high the next cycle.
- HS data latency: 1 cycle from acceptance to `phy_hs_valid_o`.
- Throughput is 1 beat/cycle while `all_rdy` is high. If `all_rdy` drops mid-burst, `hs_ready_o` drops in the same cycle.
- Minimum gap between transfers: 2 drain cycles (HS only), plus `g_guard_ticks` ticks, plus the idle wait.
- A `tick_i` coinciding with the GUARD entry cycle is not counted.

## Structure
- Shared package `dsi_pkg`: the state enumeration and the `c_max_lanes`=4 constant.
- One natural sub-module, `dsi_lane_stripe`: a registered beat→lane mapper that generates the per-lane valid mask from `hs_bytes_i` and N.

## Test plan
- 4 lanes, 3-beat HS burst with the last beat `hs_bytes_i`=2 → `phy_hs_valid_o` = 4'hF, 4'hF, 4'h3; request stays high 2 cycles after the final valid.
- 2 lanes, `hs_bytes_i`=0 → valid 4'h3; 4'hC never asserted.
- `lp_req_i` and `hs_req_i` high from reset → LP granted first, HS second, and the next simultaneous pair goes to LP again.
- LP transfer of 0xA5, 0x3C → two pass-through handshakes; then GUARD for exactly 4 ticks, and IDLE only after `phy_idle_i`=4'hF.
- `phy_hs_ready_i[1]` held low → `hs_ready_o` stays 0 and no beats are accepted.
- `rst_i` pulsed mid-HS burst → all outputs zero at the next edge; the following grant goes to LP.
